// File: rtl/ula_dispatch_pkg.sv
// Shared constants for the ULA dispatcher: funct codes, FSM encoding and
// MIPS R-type field positions.
package ula_pkg;

    localparam logic [5:0] FUNCT_ADD  = 6'd32;
    localparam logic [5:0] FUNCT_SUB  = 6'd34;
    localparam logic [5:0] FUNCT_MULT = 6'd24;
    localparam logic [5:0] FUNCT_DIV  = 6'd26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ula_dispatch_if.sv
// Dispatcher bus: instruction handshake, preload port, ALU operand/result
// path, writeback status and debug read. illegal exists only with ULA_DISPATCH_ILLEGAL_EN.
interface ula_dispatch_if;

    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] ula_a;
    logic [31:0] ula_b;
    logic [5:0]  ula_op;
    logic [32:0] ula_result;
    logic        done;
    logic        carry;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ULA_DISPATCH_ILLEGAL_EN
    logic        illegal;
`endif

    modport slave (
        input  instr, instr_valid, ld_en, ld_addr, ld_data, ula_result, dbg_addr,
        output instr_ready, ula_a, ula_b, ula_op, done, carry, dbg_data
`ifdef ULA_DISPATCH_ILLEGAL_EN
        , output illegal
`endif
    );

    modport master (
        output instr, instr_valid, ld_en, ld_addr, ld_data, ula_result, dbg_addr,
        input  instr_ready, ula_a, ula_b, ula_op, done, carry, dbg_data
`ifdef ULA_DISPATCH_ILLEGAL_EN
        , input illegal
`endif
    );

endinterface

// File: rtl/ula_dispatch_regfile.sv
// 32x32 register file: two operand read ports and a debug read port, all
// combinational, one synchronous write port; register 0 always reads zero.
module ula_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == 5'd0) ? '0 : mem_q[ra_addr];
    assign rb_data  = (rb_addr  == 5'd0) ? '0 : mem_q[rb_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/ula_dispatch.sv
// R-type dispatcher: reads operands, issues them to an external registered ALU
// and writes the result back two cycles later. Option: ULA_DISPATCH_ILLEGAL_EN.
//
// state | meaning
// IDLE  | ready for an instruction; preloads allowed; done pulses here after WB
// EXEC  | operands on ula_a/ula_b/ula_op, ALU samples them at the end of this cycle
// WB    | ula_result holds the answer; committed to rf[rd] at the end of this cycle
module ula_dispatch
    import ula_pkg::*;
(
    input logic           clock,
    input logic           reset,
    ula_dispatch_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_WB   = ST_WB;

    logic [1:0]  state_q, state_d;
    logic [31:0] ula_a_q, ula_b_q;
    logic [5:0]  ula_op_q;
    logic [4:0]  rd_q;
    logic        done_q, carry_q;

    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data;
    logic        accept, wb_commit;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign rs              = bus.instr[RS_MSB:RS_LSB];
    assign rt              = bus.instr[RT_MSB:RT_LSB];
    assign bus.instr_ready = (state_q == S_IDLE);
    assign accept          = bus.instr_valid && (state_q == S_IDLE);

`ifdef ULA_DISPATCH_ILLEGAL_EN
    logic bad_d, bad_q, illegal_q;
    logic unused_ok;

    assign bad_d = (bus.instr[OPC_MSB:OPC_LSB] != 6'd0) ||
                   !funct_supported(bus.instr[FUNCT_MSB:FUNCT_LSB]);
    assign wb_commit   = (state_q == S_WB) && !bad_q;
    assign bus.illegal = illegal_q;
    assign unused_ok   = ^bus.instr[10:6];

    always_ff @(posedge clock) begin
        if (reset) begin
            bad_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                bad_q <= bad_d;
            end
            illegal_q <= (state_q == S_WB) && bad_q;
        end
    end
`else
    logic unused_ok;

    assign wb_commit = (state_q == S_WB);
    assign unused_ok = ^{bus.instr[OPC_MSB:OPC_LSB], bus.instr[10:6]};
`endif

    // Writeback and preload share the single write port; they never overlap
    // because preloads are only honoured in IDLE.
    assign rf_we    = wb_commit || ((state_q == S_IDLE) && bus.ld_en);
    assign rf_waddr = wb_commit ? rd_q : bus.ld_addr;
    assign rf_wdata = wb_commit ? bus.ula_result[31:0] : bus.ld_data;

    ula_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .ra_addr  (rs),
        .ra_data  (rs_data),
        .rb_addr  (rt),
        .rb_data  (rt_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ula_a_q  <= '0;
            ula_b_q  <= '0;
            ula_op_q <= '0;
            rd_q     <= '0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_WB);
            if (accept) begin
                ula_a_q  <= rs_data;
                ula_b_q  <= rt_data;
                ula_op_q <= bus.instr[FUNCT_MSB:FUNCT_LSB];
                rd_q     <= bus.instr[RD_MSB:RD_LSB];
            end
            if (wb_commit) begin
                carry_q <= bus.ula_result[32];
            end
        end
    end

    assign bus.ula_a  = ula_a_q;
    assign bus.ula_b  = ula_b_q;
    assign bus.ula_op = ula_op_q;
    assign bus.done   = done_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_ula_dispatch.sv
// Scoreboard bench for ula_dispatch with a registered ALU model driving ula_result.
module tb_ula_dispatch;
    import ula_pkg::*;

`ifdef ULA_DISPATCH_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        cy;
        logic        ill;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic last_accept_done;
    logic prev_done;
    logic [32:0] alu_q = '0;

    always #5 clock = ~clock;

    ula_dispatch_if bus_if ();

    ula_dispatch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Registered ALU: samples operands every rising edge
    always @(posedge clock) begin
        case (bus_if.ula_op)
            6'd32:   alu_q <= {1'b0, bus_if.ula_a} + {1'b0, bus_if.ula_b};
            6'd34:   alu_q <= {1'b0, bus_if.ula_a} - {1'b0, bus_if.ula_b};
            6'd24:   alu_q <= {1'b0, bus_if.ula_a * bus_if.ula_b};
            6'd26:   alu_q <= (bus_if.ula_b == 32'd0) ? 33'd0 : {1'b0, bus_if.ula_a / bus_if.ula_b};
            default: alu_q <= 33'd0;
        endcase
    end
    assign bus_if.ula_result = alu_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        bus_if.dbg_addr = 5'd0;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus_if.done === 1'b1) begin
                check("done_one_cycle", {63'd0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    bus_if.dbg_addr = e.rd;
                    #1;
                    check($sformatf("wb_r%0d", e.rd), {32'd0, bus_if.dbg_data}, {32'd0, e.val});
                    check($sformatf("carry_r%0d", e.rd), {63'd0, bus_if.carry}, {63'd0, e.cy});
`ifdef ULA_DISPATCH_ILLEGAL_EN
                    check($sformatf("illegal_r%0d", e.rd), {63'd0, bus_if.illegal}, {63'd0, e.ill});
`endif
                end
            end
            prev_done = bus_if.done;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        bus_if.ld_en   = 1'b1;
        bus_if.ld_addr = a;
        bus_if.ld_data = d;
        tick();
        bus_if.ld_en = 1'b0;
    endtask

    task automatic issue(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic push,
                         input logic [31:0] val, input logic cy, input logic ill);
        exp_t e;
        int budget;
        budget = 20;
        bus_if.instr       = {opc, rs, rt, rd, 5'd0, fn};
        bus_if.instr_valid = 1'b1;
        while (bus_if.instr_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (bus_if.instr_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=%b required=1", bus_if.instr_ready);
        end
        last_accept_done = bus_if.done;
        if (push) begin
            e.rd = rd; e.val = val; e.cy = cy; e.ill = ill;
            exp_q.push_back(e);
        end
        tick();
        bus_if.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        tick();
    endtask

    initial begin
        int n;
        reset              = 1'b1;
        bus_if.instr       = '0;
        bus_if.instr_valid = 1'b0;
        bus_if.ld_en       = 1'b0;
        bus_if.ld_addr     = '0;
        bus_if.ld_data     = '0;
        repeat (2) tick();
        check("rst_ready", {63'd0, bus_if.instr_ready}, 64'd1);
        check("rst_ula_a", {32'd0, bus_if.ula_a}, 64'd0);
        check("rst_ula_b", {32'd0, bus_if.ula_b}, 64'd0);
        check("rst_ula_op", {58'd0, bus_if.ula_op}, 64'd0);
        check("rst_done", {63'd0, bus_if.done}, 64'd0);
        check("rst_carry", {63'd0, bus_if.carry}, 64'd0);
`ifdef ULA_DISPATCH_ILLEGAL_EN
        check("rst_illegal", {63'd0, bus_if.illegal}, 64'd0);
`endif
        reset = 1'b0;
        tick();

        // add r3,r1,r2 with 5+7
        load(5'd1, 32'd5);
        load(5'd2, 32'd7);
        issue(6'd0, 5'd1, 5'd2, 5'd3, 6'd32, 1'b1, 32'd12, 1'b0, 1'b0);
        check("issue_ula_a", {32'd0, bus_if.ula_a}, 64'd5);
        check("issue_ula_b", {32'd0, bus_if.ula_b}, 64'd7);
        check("issue_ula_op", {58'd0, bus_if.ula_op}, 64'd32);
        check("exec_not_ready", {63'd0, bus_if.instr_ready}, 64'd0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus_if.done !== 1'b1 && n < 10);
        check("done_latency", 64'(n), 64'd3);
        drain();

        // carry out of 0xFFFFFFFF + 1
        load(5'd1, 32'hFFFF_FFFF);
        load(5'd2, 32'd1);
        issue(6'd0, 5'd1, 5'd2, 5'd4, 6'd32, 1'b1, 32'd0, 1'b1, 1'b0);
        drain();

        // sub r5 then add r6,r5,r5 accepted in the done cycle
        load(5'd1, 32'd3);
        load(5'd2, 32'd5);
        issue(6'd0, 5'd1, 5'd2, 5'd5, 6'd34, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        issue(6'd0, 5'd5, 5'd5, 5'd6, 6'd32, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("b2b_accept_in_done", {63'd0, last_accept_done}, 64'd1);
        drain();

        // writes to r0 discarded (writeback and preload)
        issue(6'd0, 5'd1, 5'd2, 5'd0, 6'd32, 1'b1, 32'd0, 1'b0, 1'b0);
        drain();
        load(5'd0, 32'hDEAD_BEEF);
        issue(6'd0, 5'd0, 5'd0, 5'd9, 6'd32, 1'b1, 32'd0, 1'b0, 1'b0);
        drain();

        // reset during EXEC of add r7: no done, no writeback
        issue(6'd0, 5'd1, 5'd2, 5'd7, 6'd32, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", {63'd0, bus_if.instr_ready}, 64'd1);
        check("abort_ula_a", {32'd0, bus_if.ula_a}, 64'd0);
        repeat (4) tick();
        load(5'd1, 32'd1);
        issue(6'd0, 5'd7, 5'd1, 5'd10, 6'd32, 1'b1, 32'd1, 1'b0, 1'b0);
        drain();

        // set carry=1 so a skipped writeback is visible as unchanged carry
        load(5'd14, 32'hFFFF_FFFF);
        load(5'd15, 32'd1);
        issue(6'd0, 5'd14, 5'd15, 5'd13, 6'd32, 1'b1, 32'd0, 1'b1, 1'b0);
        drain();

        // unsupported funct 0x3F
        load(5'd8, 32'h55);
        issue(6'd0, 5'd1, 5'd1, 5'd8, 6'h3F, 1'b1,
              ILL_EN ? 32'h55 : 32'd0, ILL_EN ? 1'b1 : 1'b0, ILL_EN);
        check("illegal_op_issued", {58'd0, bus_if.ula_op}, 64'h3F);
        drain();

        // nonzero opcode with add funct
        load(5'd12, 32'h77);
        issue(6'd1, 5'd1, 5'd1, 5'd12, 6'd32, 1'b1,
              ILL_EN ? 32'h77 : 32'd2, ILL_EN ? 1'b1 : 1'b0, ILL_EN);
        drain();

        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
